mem_access_unit: RTL and testbench

- Sits directly upstream of Data_Memory, between the control/ALU stage and the 32x8 data memory.
- Accepts load, store and block-copy requests over a valid/ready handshake and sequences them into single-cycle memory accesses.
- Bounds-checks every address against memory depth and returns one response (data plus fault flag) per request.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and Data_Memory port bundle for mem_access_unit.
interface mem_access_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fault;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    // Requester side, which also owns the memory model.
    modport master (
        output req_valid, req_op, req_addr, req_data, req_len, mem_read_data,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
               mem_address, mem_write_data, mem_write, mem_read
    );

    // The access unit itself.
    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_len, mem_read_data,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
               mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences load/store/copy requests into single-cycle Data_Memory accesses,
// bounds-checks addresses and returns one response per request.
module mem_access_unit #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 32,
    parameter int unsigned LEN_W     = 6
) (
    input  logic             Oscillator,
    input  logic             Reset,
    mem_access_unit_if.slave bus
);
    localparam int unsigned SUM_W = ADDR_W + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STORE   = 3'd2,
        COPY_RD = 3'd3,
        COPY_WR = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;

    logic              ready_q,   ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic              mem_write_q,   mem_write_d;
    logic              mem_read_q,    mem_read_d;

    logic              accept;
    logic              req_fault;
    logic              idx_last;
    logic [SUM_W-1:0]  src_end;
    logic [SUM_W-1:0]  dst_end;

    assign accept   = bus.req_valid && ready_q;
    assign idx_last = (LEN_W'(idx_q + LEN_W'(1)) == len_q);
    assign src_end  = SUM_W'(bus.req_addr) + SUM_W'(bus.req_len) - SUM_W'(1);
    assign dst_end  = SUM_W'(bus.req_data) + SUM_W'(bus.req_len) - SUM_W'(1);

    // Op decode and range check of the request presented this cycle.
    always_comb begin
        req_fault = 1'b0;
        case (bus.req_op)
            OP_LOAD, OP_STORE: req_fault = (SUM_W'(bus.req_addr) >= SUM_W'(MEM_DEPTH));
            2'b10:             req_fault = (bus.req_len != '0) &&
                                           ((src_end >= SUM_W'(MEM_DEPTH)) ||
                                            (dst_end >= SUM_W'(MEM_DEPTH)));
            default:           req_fault = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge Oscillator) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        next_state = RESP;
                    end else begin
                        case (bus.req_op)
                            OP_LOAD:  next_state = LOAD;
                            OP_STORE: next_state = STORE;
                            default:  next_state = (bus.req_len == '0) ? RESP : COPY_RD;
                        endcase
                    end
                end
            end
            LOAD:    next_state = RESP;
            STORE:   next_state = RESP;
            COPY_RD: next_state = COPY_WR;
            COPY_WR: next_state = idx_last ? RESP : COPY_RD;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the cycle being entered; address/data/response hold when unused.
    always_comb begin
        ready_d       = (next_state == IDLE);
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_fault_d   = rsp_fault_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        case (next_state)
            LOAD: begin
                mem_read_d    = 1'b1;
                mem_address_d = bus.req_addr;
            end
            STORE: begin
                mem_write_d   = 1'b1;
                mem_address_d = bus.req_addr;
                mem_wdata_d   = bus.req_data;
            end
            COPY_RD: begin
                mem_read_d    = 1'b1;
                mem_address_d = (state == IDLE) ? bus.req_addr
                                                : ADDR_W'(src_q + ADDR_W'(idx_q) + ADDR_W'(1));
            end
            COPY_WR: begin
                // The write-data register doubles as the copy byte buffer.
                mem_write_d   = 1'b1;
                mem_address_d = ADDR_W'(dst_q + ADDR_W'(idx_q));
                mem_wdata_d   = bus.mem_read_data;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_fault_d = (state == IDLE) && req_fault;
                case (state)
                    LOAD:    rsp_data_d = bus.mem_read_data;
                    COPY_WR: rsp_data_d = DATA_W'(len_q);
                    default: rsp_data_d = '0;
                endcase
            end
            default: ;
        endcase
    end

    // Registered outputs and latched request fields.
    always_ff @(posedge Oscillator) begin
        if (Reset) begin
            ready_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_fault_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
        end else begin
            ready_q       <= ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_fault_q   <= rsp_fault_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            if (accept && (state == IDLE)) begin
                src_q <= bus.req_addr;
                dst_q <= ADDR_W'(bus.req_data);
                len_q <= bus.req_len;
                idx_q <= '0;
            end else if (state == COPY_WR) begin
                idx_q <= LEN_W'(idx_q + LEN_W'(1));
            end
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_fault      = rsp_fault_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: 32x8 memory model, reference model, directed and random requests.
module tb_mem_access_unit;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .Oscillator (clk),
        .Reset      (rst),
        .bus        (bus)
    );

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       mem_reload = 1'b0;

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp_cnt = 0;
    int n_cmp = 0, n_err = 0;

    function automatic logic [7:0] image(input int k);
        return (k == 20) ? 8'hFC : 8'(k);
    endfunction

    // Data_Memory model: combinational read, write on the rising edge.
    assign bus.mem_read_data = (bus.mem_address < 8'd32) ? mem[bus.mem_address[4:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_reload) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= image(k);
        end else if (bus.mem_write === 1'b1 && bus.mem_address < 8'd32) begin
            mem[bus.mem_address[4:0]] <= bus.mem_write_data;
        end
    end

    // Access and response counters.
    always @(posedge clk) begin
        if (bus.mem_read === 1'b1)  rd_cnt  <= rd_cnt + 1;
        if (bus.mem_write === 1'b1) wr_cnt  <= wr_cnt + 1;
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_cnt <= both_cnt + 1;
        if (bus.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic reload_mem();
        @(negedge clk) mem_reload = 1'b1;
        @(negedge clk) mem_reload = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = image(k);
    endtask

    // Reference model: expected response, latency and access counts; updates ref_mem.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [5:0] l, output logic [7:0] ed, output logic ef,
                         output int elat, output int erd, output int ewr);
        int ai = int'(a), di = int'(d), li = int'(l);
        ed = 8'h00; erd = 0; ewr = 0; elat = 1;
        if (op == 2'b11)      ef = 1'b1;
        else if (op != 2'b10) ef = (ai >= DEPTH);
        else                  ef = (li != 0) && ((ai + li - 1 >= DEPTH) || (di + li - 1 >= DEPTH));
        if (!ef) begin
            if (op == 2'b00) begin
                ed = ref_mem[ai]; elat = 2; erd = 1;
            end else if (op == 2'b01) begin
                ref_mem[ai] = d; elat = 2; ewr = 1;
            end else begin
                for (int i = 0; i < li; i++) ref_mem[di + i] = ref_mem[ai + i];
                ed = 8'(li); erd = li; ewr = li; elat = (li == 0) ? 1 : 2 * li + 1;
            end
        end
    endtask

    // Issue one request and observe its response, latency and memory accesses.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [5:0] l, output logic [7:0] rdata, output logic rfault,
                        output int lat, output int drd, output int dwr);
        int rd0, wr0, n;
        rdata = 8'h00; rfault = 1'b0; lat = -1; n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_data = d; bus.req_len = l;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op = 2'($urandom); bus.req_addr = 8'($urandom);
        bus.req_data = 8'($urandom); bus.req_len = 6'($urandom);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = c; rdata = bus.rsp_data; rfault = bus.rsp_fault;
                break;
            end
        end
        drd = rd_cnt - rd0; dwr = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 8'h00;
        bus.req_data = 8'h00; bus.req_len = 6'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = {bus.rsp_valid, bus.rsp_data, bus.rsp_fault, bus.mem_write, bus.mem_read,
               bus.mem_address[4:0], bus.req_ready, (bus.mem_write_data != 8'h00)};
        n_cmp++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 00000", got);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b, want 0", bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_high: got %b, want 1", bus.req_ready);
        end
        reload_mem();
    endtask

    task automatic test_load_store();
        logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b00};
        logic [7:0] as  [3] = '{8'd5, 8'd20, 8'd20};
        logic [7:0] rd, ed;
        logic rf, ef;
        int lat, drd, dwr, elat, erd, ewr;
        for (int t = 0; t < 3; t++) begin
            model(ops[t], as[t], 8'hA5, 6'd0, ed, ef, elat, erd, ewr);
            send(ops[t], as[t], 8'hA5, 6'd0, rd, rf, lat, drd, dwr);
            n_cmp++;
            if (rd !== ed || rf !== ef || lat != elat || drd != erd || dwr != ewr) begin
                n_err++;
                $display("FAIL load_store[%0d]: got data=%h fault=%b lat=%0d rd=%0d wr=%0d, want data=%h fault=%b lat=%0d rd=%0d wr=%0d",
                         t, rd, rf, lat, drd, dwr, ed, ef, elat, erd, ewr);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL ready_after_resp[%0d]: got ready=%b valid=%b, want ready=1 valid=0",
                         t, bus.req_ready, bus.rsp_valid);
            end
        end
        n_cmp++;
        if (mem[20] !== 8'hA5) begin
            n_err++;
            $display("FAIL store_mem20: got %h, want a5", mem[20]);
        end
    endtask

    task automatic test_faults();
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        logic [7:0] as  [4] = '{8'd32, 8'hFF, 8'd3, 8'd30};
        logic [7:0] ds  [4] = '{8'h11, 8'h22, 8'h33, 8'd0};
        logic [5:0] ls  [4] = '{6'd0, 6'd0, 6'd0, 6'd3};
        logic [7:0] rd, ed;
        logic rf, ef;
        int lat, drd, dwr, elat, erd, ewr;
        for (int t = 0; t < 4; t++) begin
            model(ops[t], as[t], ds[t], ls[t], ed, ef, elat, erd, ewr);
            send(ops[t], as[t], ds[t], ls[t], rd, rf, lat, drd, dwr);
            n_cmp++;
            if (rd !== ed || rf !== ef || lat != elat || drd != erd || dwr != ewr) begin
                n_err++;
                $display("FAIL fault[%0d]: got data=%h fault=%b lat=%0d rd=%0d wr=%0d, want data=%h fault=%b lat=%0d rd=%0d wr=%0d",
                         t, rd, rf, lat, drd, dwr, ed, ef, elat, erd, ewr);
            end
        end
    endtask

    task automatic test_copy();
        logic [7:0] as [3] = '{8'd1, 8'd0, 8'd5};
        logic [7:0] ds [3] = '{8'd24, 8'd2, 8'd9};
        logic [5:0] ls [3] = '{6'd4, 6'd4, 6'd0};
        logic [7:0] rd, ed;
        logic rf, ef;
        int lat, drd, dwr, elat, erd, ewr;
        reload_mem();
        for (int t = 0; t < 3; t++) begin
            model(2'b10, as[t], ds[t], ls[t], ed, ef, elat, erd, ewr);
            send(2'b10, as[t], ds[t], ls[t], rd, rf, lat, drd, dwr);
            n_cmp++;
            if (rd !== ed || rf !== ef || lat != elat || drd != erd || dwr != ewr) begin
                n_err++;
                $display("FAIL copy[%0d]: got data=%h fault=%b lat=%0d rd=%0d wr=%0d, want data=%h fault=%b lat=%0d rd=%0d wr=%0d",
                         t, rd, rf, lat, drd, dwr, ed, ef, elat, erd, ewr);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (mem[k < 6 ? k : 18 + k] !== ref_mem[k < 6 ? k : 18 + k]) begin
                n_err++;
                $display("FAIL copy_mem[%0d]: got %h, want %h", k < 6 ? k : 18 + k,
                         mem[k < 6 ? k : 18 + k], ref_mem[k < 6 ? k : 18 + k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wr0, rsp0;
        @(negedge clk);
        for (int n = 0; n < 20 && bus.req_ready !== 1'b1; n++) @(negedge clk);
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_addr = 8'd7; bus.req_data = 8'h5A;
        repeat (12) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        ref_mem[7] = 8'h5A;
        n_cmp++;
        if (rsp_cnt - rsp0 != 4 || wr_cnt - wr0 != 4) begin
            n_err++;
            $display("FAIL back_to_back: got rsp=%0d wr=%0d, want rsp=4 wr=4",
                     rsp_cnt - rsp0, wr_cnt - wr0);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] a, d, rd, ed;
        logic [5:0] l;
        logic rf, ef;
        int lat, drd, dwr, elat, erd, ewr;
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 35));
            d  = (op == 2'b10) ? 8'($urandom_range(0, 35)) : 8'($urandom);
            l  = 6'($urandom_range(0, 8));
            model(op, a, d, l, ed, ef, elat, erd, ewr);
            send(op, a, d, l, rd, rf, lat, drd, dwr);
            n_cmp++;
            if (rd !== ed || rf !== ef || lat != elat || drd != erd || dwr != ewr) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%0d d=%0d l=%0d: got data=%h fault=%b lat=%0d rd=%0d wr=%0d, want data=%h fault=%b lat=%0d rd=%0d wr=%0d",
                         t, op, a, d, l, rd, rf, lat, drd, dwr, ed, ef, elat, erd, ewr);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++;
            if (mem[k] !== ref_mem[k]) begin
                n_err++;
                $display("FAIL random_mem[%0d]: got %h, want %h", k, mem[k], ref_mem[k]);
            end
        end
        n_cmp++;
        if (both_cnt != 0) begin
            n_err++;
            $display("FAIL rd_wr_overlap: got %0d cycles, want 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid_copy();
        int wr0, rsp0;
        logic [19:0] got;
        reload_mem();
        @(negedge clk);
        for (int n = 0; n < 20 && bus.req_ready !== 1'b1; n++) @(negedge clk);
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr = 8'd1;
        bus.req_data = 8'd24; bus.req_len = 6'd4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        got = {bus.rsp_valid, bus.rsp_data, bus.rsp_fault, bus.mem_write, bus.mem_read,
               bus.mem_address[4:0], bus.req_ready, (bus.mem_write_data != 8'h00)};
        n_cmp++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h, want 00000", got);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_ready: got %b, want 1", bus.req_ready);
        end
        repeat (8) @(negedge clk);
        ref_mem[24] = ref_mem[1];
        n_cmp++;
        if (wr_cnt - wr0 != 1 || rsp_cnt - rsp0 != 0) begin
            n_err++;
            $display("FAIL mid_reset_activity: got wr=%0d rsp=%0d, want wr=1 rsp=0",
                     wr_cnt - wr0, rsp_cnt - rsp0);
        end
        for (int k = 24; k < 28; k++) begin
            n_cmp++;
            if (mem[k] !== ref_mem[k]) begin
                n_err++;
                $display("FAIL mid_reset_mem[%0d]: got %h, want %h", k, mem[k], ref_mem[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_faults();
        test_copy();
        test_back_to_back();
        test_random();
        test_reset_mid_copy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
